// File: rtl/conv2d_engine.sv
// conv2d_engine: sequential 2D convolution, one multiply-accumulate per cycle over a KxK window.
// Optional macro CONV_SATURATE_EN clamps results to OUT_W bits instead of wrapping.
module conv2d_engine #(
   parameter int IMG_W  = 4,
   parameter int IMG_H  = 4,
   parameter int K      = 2,
   parameter int STRIDE = 2,
   parameter int DW     = 4,
   parameter int OUT_W  = 8,
   localparam int KK    = K * K,
   localparam int KA    = (KK > 1) ? $clog2(KK) : 1,
   localparam int AW    = 2 * DW + $clog2(KK),
   localparam int NW    = (IMG_W - K) / STRIDE + 1,
   localparam int NH    = (IMG_H - K) / STRIDE + 1,
   localparam int IA    = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1,
   localparam int OA    = (NW * NH > 1) ? $clog2(NW * NH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             k_we,
   input  logic [KA-1:0]    k_addr,
   input  logic [DW-1:0]    k_data,
   output logic [IA-1:0]    img_addr,
   input  logic [DW-1:0]    img_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [OA-1:0]    out_addr,
   output logic             busy,
   output logic             done
);

   localparam int MW = (AW > OUT_W) ? AW : OUT_W;

   typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} state_t;

   state_t          state_r, state_s;
   logic [KA-1:0]   ki_r, ki_s;
   logic [KA-1:0]   kr_r, kr_s;
   logic [KA-1:0]   kc_r, kc_s;
   logic [OA-1:0]   wr_r, wr_s;
   logic [OA-1:0]   wc_r, wc_s;
   logic [AW-1:0]   acc_r, acc_s;
   logic [DW-1:0]   coef_r, coef_s;
   logic [DW-1:0]   kern_r [KK];
   logic            out_valid_r, out_valid_s;
   logic [OUT_W-1:0] out_data_r, out_data_s;
   logic [OA-1:0]   out_addr_r, out_addr_s;
   logic [IA-1:0]   img_addr_r, img_addr_s;
   logic            busy_r, busy_s;
   logic            done_r, done_s;
   logic [AW-1:0]   prod_s;
   logic [AW-1:0]   acc_sum_s;
   logic [KA-1:0]   kr_nxt_s;
   logic [KA-1:0]   kc_nxt_s;
   logic [OA-1:0]   wr_nxt_s;
   logic [OA-1:0]   wc_nxt_s;

   function automatic logic [IA-1:0] pix_addr(input int wr, input int wc, input int kr, input int kc);
      return IA'((wr * STRIDE + kr) * IMG_W + wc * STRIDE + kc);
   endfunction

   function automatic logic [OUT_W-1:0] shape_result(input logic [AW-1:0] acc);
`ifdef CONV_SATURATE_EN
      logic [MW-1:0] wide;
      wide = MW'(acc);
      if (wide > MW'({OUT_W{1'b1}})) begin
         return {OUT_W{1'b1}};
      end else begin
         return OUT_W'(acc);
      end
`else
      return OUT_W'(acc);
`endif
   endfunction

   // Next-state, datapath and registered-output values for the convolution sequencer.
   always_comb begin
      state_s     = state_r;
      ki_s        = ki_r;
      kr_s        = kr_r;
      kc_s        = kc_r;
      wr_s        = wr_r;
      wc_s        = wc_r;
      acc_s       = acc_r;
      coef_s      = coef_r;
      out_data_s  = out_data_r;
      out_addr_s  = out_addr_r;
      img_addr_s  = img_addr_r;
      prod_s      = AW'(img_data) * AW'(coef_r);
      acc_sum_s   = acc_r + prod_s;
      if (kc_r == KA'(K - 1)) begin
         kc_nxt_s = {KA{1'b0}};
         kr_nxt_s = kr_r + KA'(1);
      end else begin
         kc_nxt_s = kc_r + KA'(1);
         kr_nxt_s = kr_r;
      end
      if (wc_r == OA'(NW - 1)) begin
         wc_nxt_s = {OA{1'b0}};
         wr_nxt_s = wr_r + OA'(1);
      end else begin
         wc_nxt_s = wc_r + OA'(1);
         wr_nxt_s = wr_r;
      end
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s    = MAC;
               ki_s       = {KA{1'b0}};
               kr_s       = {KA{1'b0}};
               kc_s       = {KA{1'b0}};
               wr_s       = {OA{1'b0}};
               wc_s       = {OA{1'b0}};
               acc_s      = {AW{1'b0}};
               img_addr_s = {IA{1'b0}};
               // Coefficient is prefetched here, so a same-edge kernel write is seen only from ki=1 on.
               coef_s     = kern_r[0];
            end else begin
               state_s    = IDLE;
            end
         end
         MAC: begin
            acc_s = acc_sum_s;
            if (ki_r == KA'(KK - 1)) begin
               state_s    = EMIT;
               out_data_s = shape_result(acc_sum_s);
               out_addr_s = OA'(int'(wr_r) * NW + int'(wc_r));
            end else begin
               ki_s       = ki_r + KA'(1);
               kr_s       = kr_nxt_s;
               kc_s       = kc_nxt_s;
               img_addr_s = pix_addr(int'(wr_r), int'(wc_r), int'(kr_nxt_s), int'(kc_nxt_s));
               coef_s     = kern_r[ki_r + KA'(1)];
            end
         end
         EMIT: begin
            if (out_ready) begin
               if ((wc_r == OA'(NW - 1)) && (wr_r == OA'(NH - 1))) begin
                  state_s    = DONE;
               end else begin
                  state_s    = MAC;
                  wr_s       = wr_nxt_s;
                  wc_s       = wc_nxt_s;
                  ki_s       = {KA{1'b0}};
                  kr_s       = {KA{1'b0}};
                  kc_s       = {KA{1'b0}};
                  acc_s      = {AW{1'b0}};
                  img_addr_s = pix_addr(int'(wr_nxt_s), int'(wc_nxt_s), 0, 0);
                  coef_s     = kern_r[0];
               end
            end else begin
               state_s = EMIT;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      out_valid_s = (state_s == EMIT);
      busy_s      = (state_s != IDLE);
      done_s      = (state_s == DONE);
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         ki_r        <= {KA{1'b0}};
         kr_r        <= {KA{1'b0}};
         kc_r        <= {KA{1'b0}};
         wr_r        <= {OA{1'b0}};
         wc_r        <= {OA{1'b0}};
         acc_r       <= {AW{1'b0}};
         coef_r      <= {DW{1'b0}};
         out_valid_r <= 1'b0;
         out_data_r  <= {OUT_W{1'b0}};
         out_addr_r  <= {OA{1'b0}};
         img_addr_r  <= {IA{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         ki_r        <= ki_s;
         kr_r        <= kr_s;
         kc_r        <= kc_s;
         wr_r        <= wr_s;
         wc_r        <= wc_s;
         acc_r       <= acc_s;
         coef_r      <= coef_s;
         out_valid_r <= out_valid_s;
         out_data_r  <= out_data_s;
         out_addr_r  <= out_addr_s;
         img_addr_r  <= img_addr_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
      end
   end

   // Kernel coefficient store; writable only while idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < KK; i++) begin
            kern_r[i] <= {DW{1'b0}};
         end
      end else if ((state_r == IDLE) && k_we && (int'(k_addr) < KK)) begin
         kern_r[k_addr] <= k_data;
      end
   end

   assign img_addr  = img_addr_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_addr  = out_addr_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule
